// File: rtl/fep_pkg.sv
// rtl/fep_pkg.sv - shared FEP framing constants, checker state enum and TMR vote helper
package fep_pkg;

  localparam logic [47:0] FEP_HEADER = 48'h1eadfeb5ac0d;
  localparam logic [15:0] MIN_LEN    = 16'd60;
  localparam logic [15:0] MAX_LEN    = 16'd1514;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } fep_state_e;

  // Bitwise 2-of-3 vote across the triplicated length fields.
  function automatic logic [15:0] tmr_vote(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fep_pkt_buf.sv
// rtl/fep_pkt_buf.sv - simple dual-port packet buffer, registered read, no reset on storage
module fep_pkt_buf #(
  parameter int WIDTH = 577,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: one beat per cycle at the checker's write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data appears one cycle after rd_en and holds until the next read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fep_pkt_checker.sv
// rtl/fep_pkt_checker.sv - FEP header/length checker that forwards only fully verified packets
module fep_pkt_checker #(
  parameter int          DATA_WIDTH = 512,
  parameter int          BUF_BEATS  = 64,
  parameter logic [47:0] FEP_HEADER = fep_pkg::FEP_HEADER
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [31:0]             pkt_good_cnt,
  output logic [31:0]             pkt_drop_cnt,
  output logic [31:0]             tmr_fix_cnt
);
  import fep_pkg::*;

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int AW         = $clog2(BUF_BEATS);
  localparam int ENT_W      = DATA_WIDTH + 1 + BEAT_BYTES;

  fep_state_e state, state_n;

  logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic          s_fire, wr_en, commit, pkt_err, commit_fix;

  // Per-packet context captured from the header beat.
  logic [15:0]           beat_cnt, exp_beats;
  logic [BEAT_BYTES-1:0] exp_keep;
  logic                  pkt_fix;

  // Header decode, evaluated on whatever beat is presented.
  logic [15:0]           hdr_l0, hdr_l1, hdr_l2, hdr_lv, hdr_rem, hdr_beats;
  logic [47:0]           hdr_marker;
  logic [BEAT_BYTES-1:0] hdr_keep;
  logic                  hdr_fix, full_keep, hdr_bad, body_last, body_bad;

  assign hdr_l0     = s_axis_tdata[15:0];
  assign hdr_l1     = s_axis_tdata[31:16];
  assign hdr_l2     = s_axis_tdata[47:32];
  assign hdr_marker = s_axis_tdata[95:48];
  assign hdr_lv     = tmr_vote(hdr_l0, hdr_l1, hdr_l2);
  assign hdr_fix    = !((hdr_l0 == hdr_l1) && (hdr_l1 == hdr_l2));
  assign hdr_rem    = hdr_lv % 16'(BEAT_BYTES);
  assign hdr_beats  = (hdr_lv / 16'(BEAT_BYTES)) + {15'd0, (hdr_rem != 16'd0)};
  assign full_keep  = (s_axis_tkeep == '1);

  // Expected last-beat keep: low remainder bytes, or a full beat when the length divides evenly.
  always_comb begin
    hdr_keep = '0;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      hdr_keep[i] = (hdr_rem == 16'd0) || (16'(i) < hdr_rem);
    end
  end

  assign hdr_bad = (hdr_marker != FEP_HEADER) || (hdr_lv < MIN_LEN) || (hdr_lv > MAX_LEN)
                || (s_axis_tlast != (hdr_beats == 16'd1))
                || (s_axis_tlast ? (s_axis_tkeep != hdr_keep) : !full_keep);

  assign body_last = ((beat_cnt + 16'd1) == exp_beats);
  assign body_bad  = (s_axis_tlast != body_last)
                  || (s_axis_tlast ? (s_axis_tkeep != exp_keep) : !full_keep);

  assign s_axis_tready = rst ? 1'b0 :
                         (state == ST_DROP) ? 1'b1 : ((wr_ptr + AW'(1)) != rd_ptr);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign commit_fix    = (state == ST_HDR) ? hdr_fix : pkt_fix;

  // Next-state logic: classify each accepted beat as store, commit or error.
  always_comb begin
    state_n = state;
    wr_en   = 1'b0;
    commit  = 1'b0;
    pkt_err = 1'b0;
    case (state)
      ST_HDR: if (s_fire) begin
        if (hdr_bad) begin
          pkt_err = 1'b1;
          state_n = s_axis_tlast ? ST_HDR : ST_DROP;
        end else begin
          wr_en = 1'b1;
          if (s_axis_tlast) commit  = 1'b1;
          else              state_n = ST_BODY;
        end
      end
      ST_BODY: if (s_fire) begin
        if (body_bad) begin
          pkt_err = 1'b1;
          state_n = s_axis_tlast ? ST_HDR : ST_DROP;
        end else begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            commit  = 1'b1;
            state_n = ST_HDR;
          end
        end
      end
      ST_DROP: if (s_fire && s_axis_tlast) state_n = ST_HDR;
      default: state_n = ST_HDR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR;
    else     state <= state_n;
  end

  // Latch length/keep expectations on the header, count beats through the body.
  always_ff @(posedge clk) begin
    if (s_fire && (state == ST_HDR)) begin
      beat_cnt  <= 16'd1;
      exp_beats <= hdr_beats;
      exp_keep  <= hdr_keep;
      pkt_fix   <= hdr_fix;
    end else if (s_fire && (state == ST_BODY)) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

  // Write side pointers: advance on store, publish on commit, rewind on error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else if (pkt_err) begin
      wr_ptr <= commit_ptr;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (commit) commit_ptr <= wr_ptr + AW'(1);
    end
  end

  // CSR counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_good_cnt <= '0;
      pkt_drop_cnt <= '0;
      tmr_fix_cnt  <= '0;
    end else begin
      if (commit)               pkt_good_cnt <= pkt_good_cnt + 32'd1;
      if (pkt_err)              pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      if (commit && commit_fix) tmr_fix_cnt  <= tmr_fix_cnt + 32'd1;
    end
  end

  // Read side: RAM output stage (q) feeding the output register; rd_ptr frees a slot
  // only once its beat has been handed off downstream.
  logic             q_valid, q_move, fetch;
  logic [ENT_W-1:0] rd_data;

  assign q_move = q_valid && (!m_axis_tvalid || m_axis_tready);
  assign fetch  = (fetch_ptr != commit_ptr) && (!q_valid || q_move);

  fep_pkt_buf #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_BEATS),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({s_axis_tdata, s_axis_tlast, s_axis_tkeep}),
    .rd_en   (fetch),
    .rd_addr (fetch_ptr),
    .rd_data (rd_data)
  );

  // Read pipeline control and output valid handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr     <= '0;
      rd_ptr        <= '0;
      q_valid       <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (fetch)       fetch_ptr <= fetch_ptr + AW'(1);
      if (fetch)       q_valid   <= 1'b1;
      else if (q_move) q_valid   <= 1'b0;
      if (q_move)             m_axis_tvalid <= 1'b1;
      else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Output payload register, loaded only when the stage advances so it holds under stall.
  always_ff @(posedge clk) begin
    if (q_move) {m_axis_tdata, m_axis_tlast, m_axis_tkeep} <= rd_data;
  end

endmodule

// File: tb/tb_fep_pkt_checker.sv
// tb/tb_fep_pkt_checker.sv - table-driven scoreboard bench for fep_pkt_checker
module tb_fep_pkt_checker;

  localparam int          DW  = 512;
  localparam int          BB  = DW / 8;
  localparam logic [47:0] HDR = 48'h1eadfeb5ac0d;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [BB-1:0] s_axis_tkeep;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [BB-1:0] m_axis_tkeep;
  logic [31:0]   pkt_good_cnt, pkt_drop_cnt, tmr_fix_cnt;

  always #5 clk = ~clk;

  fep_pkt_checker #(.DATA_WIDTH(DW), .BUF_BEATS(64), .FEP_HEADER(HDR)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
    .pkt_good_cnt(pkt_good_cnt), .pkt_drop_cnt(pkt_drop_cnt), .tmr_fix_cnt(tmr_fix_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [BB-1:0] keep;
  } beat_t;

  typedef struct {
    logic [15:0] l0, l1, l2;
    logic [47:0] mk;
    int          nb;
    int          lo;
    bit          mid;
    bit          good;
    bit          fix;
  } vec_t;

  beat_t sb[$];
  beat_t pb[32];
  int    pb_n;
  vec_t  vt[15];
  int    n_cmp = 0, n_fail = 0;
  int    exp_good = 0, exp_drop = 0, exp_fix = 0;
  int    stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [BB-1:0] ones(input int n);
    logic [BB-1:0] k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  task automatic build_pkt(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                           input logic [47:0] mk, input int nb, input int lo, input bit mid);
    for (int b = 0; b < nb; b++) begin
      for (int w = 0; w < DW / 32; w++) pb[b].data[w*32 +: 32] = $urandom;
      pb[b].keep = '1;
      pb[b].last = 1'b0;
    end
    pb[0].data[15:0]  = l0;
    pb[0].data[31:16] = l1;
    pb[0].data[47:32] = l2;
    pb[0].data[95:48] = mk;
    pb[nb-1].last = 1'b1;
    pb[nb-1].keep = ones(lo);
    if (mid) pb[1].keep[5] = 1'b0;
    pb_n = nb;
  endtask

  task automatic push_pkt();
    for (int b = 0; b < pb_n; b++) sb.push_back(pb[b]);
  endtask

  task automatic send_beat(input int b);
    int w = 0;
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = pb[b].data;
    s_axis_tlast  = pb[b].last;
    s_axis_tkeep  = pb[b].keep;
    while (!s_axis_tready && w < 2000) begin
      @(negedge clk);
      w++;
      stall_cnt++;
    end
    if (!s_axis_tready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat %0d tready %0b required 1", b, s_axis_tready);
    end
    @(posedge clk);
  endtask

  task automatic send_range(input int a, input int e);
    for (int b = a; b <= e; b++) send_beat(b);
  endtask

  task automatic idle_in();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
  endtask

  task automatic drain();
    int w = 0;
    repeat (3) @(negedge clk);
    while ((sb.size() != 0 || m_axis_tvalid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0 || m_axis_tvalid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", sb.size());
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_good"}, pkt_good_cnt, exp_good);
    check({tag, "_drop"}, pkt_drop_cnt, exp_drop);
    check({tag, "_fix"},  tmr_fix_cnt,  exp_fix);
  endtask

  task automatic set_vec(input int i, input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [47:0] mk, input int nb,
                         input int lo, input bit mid, input bit good, input bit fix);
    vt[i].l0 = l0; vt[i].l1 = l1; vt[i].l2 = l2; vt[i].mk = mk;
    vt[i].nb = nb; vt[i].lo = lo; vt[i].mid = mid; vt[i].good = good; vt[i].fix = fix;
  endtask

  // Output monitor: scoreboard pop on handshake, stability check across stalls.
  beat_t hold;
  bit    hold_pend = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        if (!m_axis_tvalid || m_axis_tdata !== hold.data || m_axis_tlast !== hold.last ||
            m_axis_tkeep !== hold.keep) begin
          n_fail++;
          $display("FAIL hold_stable: valid %0b data %0h keep %0h, required held data %0h keep %0h",
                   m_axis_tvalid, m_axis_tdata[63:0], m_axis_tkeep, hold.data[63:0], hold.keep);
        end
      end
      hold_pend = 1'b0;
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL out_unexpected: beat data %0h, required no beat", m_axis_tdata[63:0]);
          end else begin
            beat_t e;
            e = sb.pop_front();
            if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tkeep !== e.keep) begin
              n_fail++;
              $display("FAIL out_beat: data %0h last %0b keep %0h, required data %0h last %0b keep %0h",
                       m_axis_tdata[63:0], m_axis_tlast, m_axis_tkeep,
                       e.data[63:0], e.last, e.keep);
            end
          end
        end else begin
          hold_pend = 1'b1;
          hold.data = m_axis_tdata;
          hold.last = m_axis_tlast;
          hold.keep = m_axis_tkeep;
        end
      end
    end
  end

  initial begin
    // l0, l1, l2, marker, beats driven, last-beat ones, bad mid keep, good, tmr fix
    set_vec(0,  16'd100, 16'd100,  16'd100, HDR,   2, 36, 0, 1, 0);
    set_vec(1,  16'd100, 16'h0fff, 16'd100, HDR,   2, 36, 0, 1, 1);
    set_vec(2,  16'd150, 16'd150,  16'd150, 48'h0, 3, 22, 0, 0, 0);
    set_vec(3,  16'd100, 16'd100,  16'd100, HDR,   2, 36, 0, 1, 0);
    set_vec(4,  16'd200, 16'd200,  16'd200, HDR,   3, 8,  0, 0, 0);
    set_vec(5,  16'd60,  16'd60,   16'd60,  HDR,   1, 60, 0, 1, 0);
    set_vec(6,  16'd59,  16'd59,   16'd59,  HDR,   1, 59, 0, 0, 0);
    set_vec(7,  16'd1515,16'd1515, 16'd1515,HDR,  24, 43, 0, 0, 0);
    set_vec(8,  16'd128, 16'd128,  16'd128, HDR,   2, 64, 0, 1, 0);
    set_vec(9,  16'd100, 16'd100,  16'd100, HDR,   2, 35, 0, 0, 0);
    set_vec(10, 16'd100, 16'd100,  16'd100, HDR,   3, 36, 0, 0, 0);
    set_vec(11, 16'd200, 16'd200,  16'd200, HDR,   4, 8,  1, 0, 0);
    set_vec(12, 16'd1514,16'd1514, 16'd1514,HDR,  24, 42, 0, 1, 0);
    set_vec(13, 16'h0064,16'h0065, 16'h0066,HDR,   2, 36, 0, 1, 1);
    set_vec(14, 16'd100, 16'd100,  16'd100, HDR,   1, 36, 0, 0, 0);

    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tkeep = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check_cnts("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      build_pkt(vt[i].l0, vt[i].l1, vt[i].l2, vt[i].mk, vt[i].nb, vt[i].lo, vt[i].mid);
      if (vt[i].good) push_pkt();
      send_range(0, pb_n - 1);
      idle_in();
      drain();
      if (vt[i].good) exp_good++;
      else            exp_drop++;
      if (vt[i].good && vt[i].fix) exp_fix++;
      check_cnts($sformatf("v%0d", i));
      check($sformatf("v%0d_ptr", i), dut.wr_ptr, dut.commit_ptr);
    end

    // First-beat latency: two cycles from the commit edge.
    build_pkt(16'd60, 16'd60, 16'd60, HDR, 1, 60, 0);
    push_pkt();
    send_beat(0);
    idle_in();
    check("lat_c0", m_axis_tvalid, 0);
    @(negedge clk);
    check("lat_c1", m_axis_tvalid, 0);
    @(negedge clk);
    check("lat_c2", m_axis_tvalid, 1);
    drain();
    exp_good++;
    check_cnts("lat");

    // Backpressure: buffer fills after 63 beats, then drains cleanly and wraps.
    @(negedge clk);
    m_axis_tready = 1'b0;
    stall_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      build_pkt(16'd1514, 16'd1514, 16'd1514, HDR, 24, 42, 0);
      push_pkt();
      send_range(0, 23);
    end
    build_pkt(16'd1514, 16'd1514, 16'd1514, HDR, 24, 42, 0);
    push_pkt();
    send_range(0, 14);
    idle_in();
    check("bp_no_early_stall", stall_cnt, 0);
    check("bp_full_tready", s_axis_tready, 0);
    repeat (5) @(negedge clk);
    check("bp_full_hold", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    send_range(15, 23);
    for (int p = 0; p < 2; p++) begin
      build_pkt(16'd1514, 16'd1514, 16'd1514, HDR, 24, 42, 0);
      push_pkt();
      send_range(0, 23);
    end
    idle_in();
    drain();
    exp_good += 5;
    check_cnts("bp");

    // Reset mid-body with a committed packet still waiting downstream.
    @(negedge clk);
    m_axis_tready = 1'b0;
    build_pkt(16'd100, 16'd100, 16'd100, HDR, 2, 36, 0);
    send_range(0, 1);
    idle_in();
    repeat (4) @(negedge clk);
    check("rr_pending", m_axis_tvalid, 1);
    build_pkt(16'd200, 16'd200, 16'd200, HDR, 4, 8, 0);
    send_range(0, 1);
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("rr_s_tready", s_axis_tready, 0);
    check("rr_m_tvalid", m_axis_tvalid, 0);
    rst = 1'b0;
    exp_good = 0; exp_drop = 0; exp_fix = 0;
    @(negedge clk);
    check("rr_after_valid", m_axis_tvalid, 0);
    check_cnts("rr");
    m_axis_tready = 1'b1;
    build_pkt(16'd100, 16'd100, 16'd100, HDR, 2, 36, 0);
    push_pkt();
    send_range(0, 1);
    idle_in();
    drain();
    exp_good++;
    check_cnts("rr_next");
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fep_pkt_checker.md
FEP_PKT_CHECKER -- requirements
Module: fep_pkt_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning AXIS data width in bits; BEAT_BYTES = DATA_WIDTH/8.
REQ-002 SHALL have parameter BUF_BEATS, default 64, meaning packet buffer depth in beats; power of 2 and at least 32.
REQ-003 SHALL have parameter FEP_HEADER, default 48'h1eadfeb5ac0d, meaning the expected header marker.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports s_axis_tdata/tvalid/tready/tlast/tkeep, input/input/output/input/input, widths DATA_WIDTH/1/1/1/BEAT_BYTES: the upstream DDR-readback stream carrying FEP-framed packets.
REQ-007 SHALL have ports m_axis_tdata/tvalid/tready/tlast/tkeep, output/output/input/output/output, same widths: the checked packet stream to AMPER.
REQ-008 SHALL have ports pkt_good_cnt, pkt_drop_cnt and tmr_fix_cnt, each an output of 32 bits: the CSR counters.

Function
REQ-009 SHALL treat the first accepted beat after reset, or after an accepted tlast, as the header beat.
REQ-010 SHALL extract the header fields from the header beat: L0=tdata[15:0], L1=[31:16], L2=[47:32], marker=[95:48].
REQ-011 SHALL compute the length Lv as the bitwise majority of L0/L1/L2, and increment tmr_fix_cnt when the three are not all equal and the packet commits.
REQ-012 SHALL compute the expected beats as ceil(Lv/BEAT_BYTES), using 16-bit arithmetic with no truncation before the divide.
REQ-013 SHALL compute the expected last-beat tkeep as the low (Lv mod BEAT_BYTES) bits set, or all ones when the remainder is 0.
REQ-014 SHALL mark a packet in error on any of the following:
- marker != FEP_HEADER;
- Lv < 60 or Lv > 1514;
- tlast arriving before the expected beat;
- no tlast on the expected beat;
- a non-last beat with tkeep != all ones;
- last-beat tkeep != the expected tkeep.
REQ-015 SHALL implement a state machine with states ST_HDR, ST_BODY and ST_DROP, reset state ST_HDR.
- ST_HDR -> ST_BODY on a good header without tlast.
- ST_HDR stays in ST_HDR on a good one-beat packet (commit) or on an error with tlast.
- ST_HDR -> ST_DROP on an error without tlast.
- ST_BODY -> ST_HDR on a good last beat (commit) or on an error with tlast.
- ST_BODY -> ST_DROP on an error without tlast.
- ST_DROP -> ST_HDR on an accepted tlast.
REQ-016 SHALL store beats into the buffer at wr_ptr, and SHALL NOT write any beat while in ST_DROP.
REQ-017 SHALL, on commit, set commit_ptr to wr_ptr+1 and increment pkt_good_cnt.
REQ-018 SHALL, on error, set wr_ptr back to commit_ptr and increment pkt_drop_cnt exactly once per packet.
REQ-019 SHALL drive s_axis_tready = ~(wr_ptr+1 == rd_ptr) in ST_HDR and ST_BODY, and s_axis_tready = 1 in ST_DROP.
REQ-020 SHALL make only committed beats (rd_ptr != commit_ptr) visible on the output.
- The output uses a one-entry register stage.
- First-beat latency is 2 cycles from the commit edge.
- Output order is preserved.
REQ-021 SHALL hold m_axis_tdata/tlast/tkeep stable while tvalid=1 and tready=0, and SHALL NOT drop tvalid without a handshake.
REQ-022 SHALL forward data unmodified, including the header beat, with tkeep exactly as received.
REQ-023 SHALL handle a buffer write and an output read in the same cycle without loss.
REQ-024 SHALL handle pointer wrap-around modulo BUF_BEATS correctly.
REQ-025 SHALL let counters wrap at 2^32.

Reset
REQ-026 SHALL, while rst=1, set: state=ST_HDR, wr_ptr=commit_ptr=rd_ptr=0, m_axis_tvalid=0, s_axis_tready=0, all counters=0.
REQ-027 SHALL, on reset mid-packet, discard any partial and committed-but-unsent data, and SHALL treat the first beat after reset as a header.
REQ-028 SHALL NOT reset the buffer memory contents.

Structure
REQ-029 SHALL take FEP_HEADER, MIN_LEN=60, MAX_LEN=1514 and the state enum from the shared package fep_pkg.
REQ-030 SHALL implement the buffer as one sub-module, fep_pkt_buf: a simple dual-port RAM of {tdata, tlast, tkeep}, 1-cycle read, inferable as BRAM/URAM.

Verification
REQ-031 SHALL cover: a good packet with Lv=100 (L0=L1=L2=100), 2 beats, last tkeep=36 ones -> 2 beats out unchanged, pkt_good_cnt=1.
REQ-032 SHALL cover: a good packet with L1=0x0fff and L0=L2=100 -> forwarded, tmr_fix_cnt=1.
REQ-033 SHALL cover: marker=48'h0 on a 3-beat packet -> nothing output, pkt_drop_cnt=1, the next good packet passes.
REQ-034 SHALL cover: Lv=200 (4 beats) with tlast on beat 3 -> dropped, then wr_ptr==commit_ptr, and a following 1-beat Lv=60 packet is output with tkeep=60 ones.
REQ-035 SHALL cover: m_axis_tready=0 while 24-beat Lv=1514 packets are sent -> s_axis_tready falls after 63 beats, no corruption after release, pointers wrap.
REQ-036 SHALL cover: rst asserted mid-body with one committed packet pending -> after reset m_axis_tvalid=0, counters=0, the next beat is parsed as a header.
